// File: rtl/roll_uart_tx_if.sv
// Request/response bundle for roll_uart_tx: message request handshake, completion pulse and serial line.
// The master drives the request fields; the slave (the transmitter) drives ready, done and the UART line.
interface roll_uart_tx_if;
    logic       i_valid;
    logic       i_raw;
    logic [4:0] i_dieRoll;
    logic [7:0] i_byte;
    logic       o_ready;
    logic       o_done;
    logic       o_uart;

    modport master (
        output i_valid, i_raw, i_dieRoll, i_byte,
        input  o_ready, o_done, o_uart
    );

    modport slave (
        input  i_valid, i_raw, i_dieRoll, i_byte,
        output o_ready, o_done, o_uart
    );
endinterface

// File: rtl/roll_uart_tx.sv
// 8N1 UART sender for a die roll (decimal ASCII + CR LF) or a raw byte; 10*CLKS_PER_BIT cycles per char.
// One message in flight: o_ready is low from the accept edge until the last stop bit ends; i_valid is ignored meanwhile.
module roll_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    roll_uart_tx_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_baud,  w_baud_nxt;
    logic [2:0]  r_bit,   w_bit_nxt;
    logic [1:0]  r_char,  w_char_nxt;
    logic        r_uart,  w_uart_nxt;
    logic        r_ready, w_ready_nxt;
    logic        r_done,  w_done_nxt;
    logic        r_raw;
    logic [4:0]  r_roll;
    logic [7:0]  r_byte;
    logic        w_capture;

    logic [5:0]  w_v;
    logic [1:0]  w_tens;
    logic [3:0]  w_ones;
    logic [1:0]  w_idx;
    logic [1:0]  w_last;
    logic [7:0]  w_char;
    logic        w_baud_end;

    // Message content is derived from the captured request, so it cannot change mid-message.
    always_comb begin
        w_v    = {1'b0, r_roll} + 6'd1;
        w_tens = 2'd0;
        w_ones = w_v[3:0];
        if (w_v >= 6'd30) begin
            w_tens = 2'd3;
            w_ones = 4'(w_v - 6'd30);
        end else if (w_v >= 6'd20) begin
            w_tens = 2'd2;
            w_ones = 4'(w_v - 6'd20);
        end else if (w_v >= 6'd10) begin
            w_tens = 2'd1;
            w_ones = 4'(w_v - 6'd10);
        end

        // Single-digit messages skip the tens slot.
        w_idx  = (w_tens == 2'd0) ? r_char + 2'd1 : r_char;
        w_last = r_raw ? 2'd0 : ((w_tens == 2'd0) ? 2'd2 : 2'd3);

        w_char = 8'h0A;
        if (r_raw) begin
            w_char = r_byte;
        end else begin
            case (w_idx)
                2'd0:    w_char = 8'h30 | {6'b0, w_tens};
                2'd1:    w_char = 8'h30 | {4'b0, w_ones};
                2'd2:    w_char = 8'h0D;
                default: w_char = 8'h0A;
            endcase
        end
    end

    assign w_baud_end = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_char_nxt  = r_char;
        w_uart_nxt  = r_uart;
        w_ready_nxt = r_ready;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.i_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = START;
                    w_baud_nxt  = 16'd0;
                    w_bit_nxt   = 3'd0;
                    w_char_nxt  = 2'd0;
                    w_uart_nxt  = 1'b0;
                    w_ready_nxt = 1'b0;
                end
            end
            START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = 16'd0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = DATA;
                    w_uart_nxt  = w_char[0];
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = 16'd0;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                        w_uart_nxt  = 1'b1;
                    end else begin
                        w_bit_nxt  = r_bit + 3'd1;
                        w_uart_nxt = w_char[r_bit + 3'd1];
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = 16'd0;
                    if (r_char == w_last) begin
                        w_state_nxt = IDLE;
                        w_ready_nxt = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_uart_nxt  = 1'b1;
                        w_char_nxt  = 2'd0;
                    end else begin
                        w_char_nxt  = r_char + 2'd1;
                        w_state_nxt = START;
                        w_uart_nxt  = 1'b0;
                    end
                end else begin
                    w_baud_nxt = r_baud + 16'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_char  <= 2'd0;
            r_uart  <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_raw   <= 1'b0;
            r_roll  <= 5'd0;
            r_byte  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_char  <= w_char_nxt;
            r_uart  <= w_uart_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
            if (w_capture) begin
                r_raw  <= bus.i_raw;
                r_roll <= bus.i_dieRoll;
                r_byte <= bus.i_byte;
            end
        end
    end

    assign bus.o_uart  = r_uart;
    assign bus.o_ready = r_ready;
    assign bus.o_done  = r_done;
endmodule

// File: tb/tb_roll_uart_tx.sv
// Directed bench for roll_uart_tx at CLKS_PER_BIT=4: table of messages with hand-computed ASCII bytes,
// plus reset, busy-request and mid-frame-reset sequences. Outputs are sampled on the falling edge.
module tb_roll_uart_tx;
    localparam int CPB = 4;

    typedef struct packed {
        logic            raw;
        logic [4:0]      roll;
        logic [7:0]      byt;
        logic [2:0]      n;
        logic [3:0][7:0] chars;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    roll_uart_tx_if u_if ();

    roll_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int cnt = 0;
        @(negedge clk);
        while (!u_if.o_ready && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        chk({nm, "_ready_wait"}, 32'(u_if.o_ready), 32'd1);
    endtask

    task automatic send_check(input vec_t v, input int busy_at, input string nm);
        int  total;
        int  ready_hi = 0;
        int  done_hi  = 0;
        logic bad [4][10];
        for (int c = 0; c < 4; c++)
            for (int b = 0; b < 10; b++)
                bad[c][b] = 1'b0;
        wait_ready(nm);
        u_if.i_valid   = 1'b1;
        u_if.i_raw     = v.raw;
        u_if.i_dieRoll = v.roll;
        u_if.i_byte    = v.byt;
        @(posedge clk);
        total = 10 * int'(v.n) * CPB;
        for (int t = 0; t < total; t++) begin
            int   c, b;
            logic e;
            @(negedge clk);
            c = t / (10 * CPB);
            b = (t / CPB) % 10;
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : v.chars[c][b-1];
            if (u_if.o_uart !== e) bad[c][b] = 1'b1;
            if (u_if.o_ready !== 1'b0) ready_hi++;
            if (u_if.o_done  !== 1'b0) done_hi++;
            if (t == 0) begin
                u_if.i_valid   = 1'b0;
                u_if.i_dieRoll = ~v.roll;
                u_if.i_byte    = ~v.byt;
                u_if.i_raw     = ~v.raw;
            end
            if (t == busy_at) begin
                u_if.i_valid   = 1'b1;
                u_if.i_raw     = 1'b0;
                u_if.i_dieRoll = 5'd0;
            end
            if (t == busy_at + 1) u_if.i_valid = 1'b0;
        end
        for (int c = 0; c < int'(v.n); c++)
            for (int b = 0; b < 10; b++) begin
                checks++;
                if (bad[c][b]) begin
                    failures++;
                    $display("FAIL %s_line char %0d bit %0d: wrong level, expected frame of %02h", nm, c, b, v.chars[c]);
                end
            end
        chk({nm, "_ready_low_cycles_hi"}, 32'(ready_hi), 32'd0);
        chk({nm, "_done_early"}, 32'(done_hi), 32'd0);
        @(negedge clk);
        chk({nm, "_done_end"}, 32'(u_if.o_done), 32'd1);
        chk({nm, "_ready_end"}, 32'(u_if.o_ready), 32'd1);
        chk({nm, "_uart_end"}, 32'(u_if.o_uart), 32'd1);
        @(negedge clk);
        chk({nm, "_done_drop"}, 32'(u_if.o_done), 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        // {raw, roll, byte, nchars, {c3,c2,c1,c0}}
        vecs[0] = '{1'b0, 5'd5,  8'h00, 3'd3, {8'h00, 8'h0A, 8'h0D, 8'h36}};
        vecs[1] = '{1'b0, 5'd19, 8'h00, 3'd4, {8'h0A, 8'h0D, 8'h30, 8'h32}};
        vecs[2] = '{1'b0, 5'd31, 8'h00, 3'd4, {8'h0A, 8'h0D, 8'h32, 8'h33}};
        vecs[3] = '{1'b0, 5'd8,  8'h00, 3'd3, {8'h00, 8'h0A, 8'h0D, 8'h39}};
        vecs[4] = '{1'b0, 5'd9,  8'h00, 3'd4, {8'h0A, 8'h0D, 8'h30, 8'h31}};
        vecs[5] = '{1'b0, 5'd0,  8'h00, 3'd3, {8'h00, 8'h0A, 8'h0D, 8'h31}};
        vecs[6] = '{1'b1, 5'd12, 8'hA5, 3'd1, {8'h00, 8'h00, 8'h00, 8'hA5}};
        vecs[7] = '{1'b1, 5'd3,  8'h00, 3'd1, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[8] = '{1'b1, 5'd31, 8'hFF, 3'd1, {8'h00, 8'h00, 8'h00, 8'hFF}};

        checks   = 0;
        failures = 0;

        // Reset held with a pending request: nothing may be sent.
        begin
            int low_cnt = 0;
            rst_n          = 1'b0;
            u_if.i_valid   = 1'b1;
            u_if.i_raw     = 1'b0;
            u_if.i_dieRoll = 5'd5;
            u_if.i_byte    = 8'h00;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (u_if.o_uart !== 1'b1) low_cnt++;
            end
            chk("rst_uart_low_cycles", 32'(low_cnt), 32'd0);
            chk("rst_uart", 32'(u_if.o_uart), 32'd1);
            chk("rst_ready", 32'(u_if.o_ready), 32'd1);
            chk("rst_done", 32'(u_if.o_done), 32'd0);
            u_if.i_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end

        for (int i = 0; i < 9; i++)
            send_check(vecs[i], -1, $sformatf("vec%0d", i));

        // Request during a busy message must be dropped.
        send_check(vecs[1], 50, "busy");
        begin
            int extra = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (u_if.o_uart !== 1'b1 || u_if.o_ready !== 1'b1) extra++;
            end
            chk("busy_no_second_msg", 32'(extra), 32'd0);
        end

        // Reset during data bit 3 of a raw frame.
        begin
            int bad_cnt = 0;
            wait_ready("mrst");
            u_if.i_valid = 1'b1;
            u_if.i_raw   = 1'b1;
            u_if.i_byte  = 8'hA5;
            @(posedge clk);
            for (int t = 0; t <= 4 * CPB + 1; t++) begin
                @(negedge clk);
                u_if.i_valid = 1'b0;
            end
            chk("mrst_pre_ready", 32'(u_if.o_ready), 32'd0);
            rst_n = 1'b0;
            #1;
            chk("mrst_uart", 32'(u_if.o_uart), 32'd1);
            chk("mrst_ready", 32'(u_if.o_ready), 32'd1);
            chk("mrst_done", 32'(u_if.o_done), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (u_if.o_done !== 1'b0 || u_if.o_uart !== 1'b1) bad_cnt++;
            end
            chk("mrst_quiet_after", 32'(bad_cnt), 32'd0);
        end
        send_check(vecs[6], -1, "mrst_resend");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
